matrix_mem_responder: RTL and testbench

- Responder end of the matrix memory interface. Holds the Tetris playfield as height_p rows of width_p bits. Row 0 is the top; row height_p-1 is the bottom.
- Serves the executors (line-check/compaction, piece placement): one combinational read port and one synchronous write port.
- Also provides a bulk-clear sequencer for new games, a free-running row scan-out for the display path, and per-row full flags.

---
 rtl/tetris_pkg.sv | 19 +
 rtl/matrix_row_scanner.sv | 50 +++++
 rtl/matrix_mem_responder.sv | 174 +++++++++++++++++
 tb/tb_matrix_mem_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared playfield types and default geometry
//
// Purpose: types and constants shared by the matrix memory responder and
// every executor that talks to it, so all agree on playfield geometry.
//   matrix_width_lp     default playfield columns (bits per row)
//   matrix_height_lp    default playfield rows
//   matrix_mem_state_e  bulk-clear sequencer states
package tetris_pkg;

  localparam int matrix_width_lp  = 16;
  localparam int matrix_height_lp = 32;

  typedef enum logic [1:0] {
    eIDLE  = 2'd0,
    eCLEAR = 2'd1,
    eDONE  = 2'd2
  } matrix_mem_state_e;

endpackage

// File: rtl/matrix_row_scanner.sv
// rtl/matrix_row_scanner.sv - wrapping playfield row scan counter
//
// Purpose: free-running row address for the display path. The address
// advances every cycle and wraps from height_p-1 to 0; the row data is
// registered on the same edge so address and data stay paired.
// Ports:
//   clk_i        clock
//   reset_i      asynchronous active-high reset
//   next_data_i  contents of the row at next_addr_o (pre-edge value)
//   next_addr_o  row address the scanner moves to on the next edge
//   scan_addr_o  current scan row
//   scan_data_o  contents of scan_addr_o, captured when it was entered
//   frame_o      high while scan_addr_o is the last row
module matrix_row_scanner
  import tetris_pkg::*;
#(
  parameter int width_p  = matrix_width_lp,
  parameter int height_p = matrix_height_lp
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [width_p-1:0]          next_data_i,
  output logic [$clog2(height_p)-1:0] next_addr_o,
  output logic [$clog2(height_p)-1:0] scan_addr_o,
  output logic [width_p-1:0]          scan_data_o,
  output logic                        frame_o
);

  localparam int addr_w_lp = $clog2(height_p);
  localparam logic [addr_w_lp-1:0] last_addr_lp = addr_w_lp'(height_p - 1);

  // Explicit wrap: height_p need not be a power of two.
  assign next_addr_o = (scan_addr_o == last_addr_lp) ? '0
                                                     : scan_addr_o + addr_w_lp'(1);

  // frame_o is registered from the next address so it lines up with
  // scan_addr_o without a comparator on the output path.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      scan_addr_o <= '0;
      scan_data_o <= '0;
      frame_o     <= 1'b0;
    end else begin
      scan_addr_o <= next_addr_o;
      scan_data_o <= next_data_i;
      frame_o     <= (next_addr_o == last_addr_lp);
    end
  end

endmodule

// File: rtl/matrix_mem_responder.sv
// rtl/matrix_mem_responder.sv - playfield matrix memory responder
//
// Purpose: holds the playfield as height_p rows of width_p bits (row 0 is
// the top). Offers a zero-latency read port, a synchronous write port, a
// bulk-clear sequencer, a free-running display scan and per-row full flags.
// Ports:
//   clk_i            clock
//   reset_i          asynchronous active-high reset (zeroes all rows)
//   clear_v_i        start bulk clear (sampled only in eIDLE)
//   ready_o          high when not clearing; writes accepted only then
//   clear_done_o     one-cycle pulse after the last row is cleared
//   mm_read_addr_i   read row address
//   mm_read_data_o   row contents, same cycle ('0 for out-of-range rows)
//   mm_write_addr_i  write row address (out-of-range ignored)
//   mm_write_data_i  write data
//   mm_write_v_i     write enable
//   scan_addr_o      display scan row
//   scan_data_o      contents of the scan row
//   frame_o          high while scan_addr_o is the last row
//   full_rows_o      bit r set when row r is all ones
//   top_occupied_o   row 0 is nonzero
module matrix_mem_responder
  import tetris_pkg::*;
#(
  parameter int width_p  = matrix_width_lp,
  parameter int height_p = matrix_height_lp,
  parameter bit debug_p  = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        clear_v_i,
  output logic                        ready_o,
  output logic                        clear_done_o,
  input  logic [$clog2(height_p)-1:0] mm_read_addr_i,
  output logic [width_p-1:0]          mm_read_data_o,
  input  logic [$clog2(height_p)-1:0] mm_write_addr_i,
  input  logic [width_p-1:0]          mm_write_data_i,
  input  logic                        mm_write_v_i,
  output logic [$clog2(height_p)-1:0] scan_addr_o,
  output logic [width_p-1:0]          scan_data_o,
  output logic                        frame_o,
  output logic [height_p-1:0]         full_rows_o,
  output logic                        top_occupied_o
);

  localparam int addr_w_lp = $clog2(height_p);
  localparam logic [addr_w_lp-1:0] last_addr_lp = addr_w_lp'(height_p - 1);

  logic [width_p-1:0]   mem_r [height_p];

  matrix_mem_state_e    state_r, state_n;
  logic [addr_w_lp-1:0] clear_addr_r, clear_addr_n;
  logic                 clear_en;
  logic                 write_en;

  logic [addr_w_lp-1:0] scan_next_addr;
  logic [width_p-1:0]   scan_next_data;

  // ---------------- clear sequencer: state register ----------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r      <= eIDLE;
      clear_addr_r <= last_addr_lp;
    end else begin
      state_r      <= state_n;
      clear_addr_r <= clear_addr_n;
    end
  end

  // ---------------- clear sequencer: next state ----------------
  // Clearing runs bottom row first; row 0 is the last one zeroed, so a
  // clear always takes exactly height_p cycles.
  always_comb begin
    state_n      = state_r;
    clear_addr_n = clear_addr_r;
    unique case (state_r)
      eIDLE: begin
        if (clear_v_i) begin
          state_n      = eCLEAR;
          clear_addr_n = last_addr_lp;
        end
      end
      eCLEAR: begin
        if (clear_addr_r == '0) begin
          state_n      = eDONE;
          clear_addr_n = last_addr_lp;
        end else begin
          clear_addr_n = clear_addr_r - addr_w_lp'(1);
        end
      end
      eDONE: begin
        state_n = eIDLE;
      end
      default: begin
        state_n      = eIDLE;
        clear_addr_n = last_addr_lp;
      end
    endcase
  end

  // ---------------- clear sequencer: outputs ----------------
  always_comb begin
    ready_o      = 1'b1;
    clear_done_o = 1'b0;
    clear_en     = 1'b0;
    unique case (state_r)
      eIDLE:  ;
      eCLEAR: begin
        ready_o  = 1'b0;
        clear_en = 1'b1;
      end
      eDONE:  clear_done_o = 1'b1;
      default: ;
    endcase
  end

  // ---------------- storage ----------------
  // Writes presented while not ready are dropped, not queued.
  assign write_en = mm_write_v_i && ready_o && (mm_write_addr_i <= last_addr_lp);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int r = 0; r < height_p; r++) begin
        mem_r[r] <= '0;
      end
    end else if (clear_en) begin
      mem_r[clear_addr_r] <= '0;
    end else if (write_en) begin
      mem_r[mm_write_addr_i] <= mm_write_data_i;
    end
  end

  // Combinational read: sees pre-edge contents, so a same-cycle write to
  // the read row shows up only on the following cycle.
  assign mm_read_data_o = (mm_read_addr_i <= last_addr_lp) ? mem_r[mm_read_addr_i] : '0;

  always_comb begin
    full_rows_o = '0;
    for (int r = 0; r < height_p; r++) begin
      full_rows_o[r] = &mem_r[r];
    end
  end

  assign top_occupied_o = |mem_r[0];

  // ---------------- display scan ----------------
  assign scan_next_data = mem_r[scan_next_addr];

  matrix_row_scanner #(
    .width_p (width_p),
    .height_p(height_p)
  ) scanner (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .next_data_i(scan_next_data),
    .next_addr_o(scan_next_addr),
    .scan_addr_o(scan_addr_o),
    .scan_data_o(scan_data_o),
    .frame_o    (frame_o)
  );

  // ---------------- debug-build sanity checks ----------------
  if (debug_p) begin : g_debug_checks
    always_ff @(posedge clk_i) begin
      if (!reset_i) begin
        assert (clear_addr_r <= last_addr_lp)
          else $error("clear address out of range: %0d", clear_addr_r);
        assert (state_r inside {eIDLE, eCLEAR, eDONE})
          else $error("illegal clear state: %0d", state_r);
      end
    end
  end

endmodule

// File: tb/tb_matrix_mem_responder.sv
// tb/tb_matrix_mem_responder.sv - directed self-checking bench for matrix_mem_responder
module tb_matrix_mem_responder;

  logic        clk;
  logic        rst;

  logic        clear_v, ready, clear_done;
  logic [4:0]  raddr, waddr, scan_addr;
  logic [15:0] rdata, wdata, scan_data;
  logic        wv, frame, top;
  logic [31:0] full_rows;

  logic        clear_v20, ready20, clear_done20;
  logic [4:0]  raddr20, waddr20, scan_addr20;
  logic [15:0] rdata20, wdata20, scan_data20;
  logic        wv20, frame20, top20;
  logic [19:0] full_rows20;

  int checks = 0;
  int errors = 0;

  logic [15:0] model [32];
  logic [63:0] exp_q [$];

  matrix_mem_responder #(.width_p(16), .height_p(32), .debug_p(1'b1)) dut (
    .clk_i(clk), .reset_i(rst), .clear_v_i(clear_v), .ready_o(ready),
    .clear_done_o(clear_done), .mm_read_addr_i(raddr), .mm_read_data_o(rdata),
    .mm_write_addr_i(waddr), .mm_write_data_i(wdata), .mm_write_v_i(wv),
    .scan_addr_o(scan_addr), .scan_data_o(scan_data), .frame_o(frame),
    .full_rows_o(full_rows), .top_occupied_o(top)
  );

  matrix_mem_responder #(.width_p(16), .height_p(20), .debug_p(1'b1)) dut20 (
    .clk_i(clk), .reset_i(rst), .clear_v_i(clear_v20), .ready_o(ready20),
    .clear_done_o(clear_done20), .mm_read_addr_i(raddr20), .mm_read_data_o(rdata20),
    .mm_write_addr_i(waddr20), .mm_write_data_i(wdata20), .mm_write_v_i(wv20),
    .scan_addr_o(scan_addr20), .scan_data_o(scan_data20), .frame_o(frame20),
    .full_rows_o(full_rows20), .top_occupied_o(top20)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read one row of the 32-row instance on its own cycle; expectation from the model.
  task automatic rd(input string tag, input int a);
    @(negedge clk);
    exp_q.push_back({48'd0, model[a]});
    raddr = 5'(a);
    #1;
    chk(tag, {48'd0, rdata}, exp_q.pop_front());
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    @(negedge clk);
    waddr = 5'(a);
    wdata = d;
    wv    = 1'b1;
    @(posedge clk);
    #1;
    wv = 1'b0;
    model[a] = d;
  endtask

  initial begin
    int n, cnt, prev, pulses;
    bit seen7;
    rst = 1'b1; clear_v = 0; raddr = 0; waddr = 0; wdata = 0; wv = 0;
    clear_v20 = 0; raddr20 = 0; waddr20 = 0; wdata20 = 0; wv20 = 0;
    for (int i = 0; i < 32; i++) model[i] = '0;

    // ---- reset state ----
    #12;
    chk("rst_ready", ready, 1'b1);
    chk("rst_clear_done", clear_done, 1'b0);
    chk("rst_scan_addr", scan_addr, 5'd0);
    chk("rst_scan_data", scan_data, 16'h0);
    chk("rst_frame", frame, 1'b0);
    chk("rst_full_rows", full_rows, 32'h0);
    chk("rst_top", top, 1'b0);
    chk("rst_ready20", ready20, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 32; a++) rd("reset_read", a);
    chk("post_rst_full_rows", full_rows, 32'h0);
    chk("post_rst_ready", ready, 1'b1);

    // ---- write then read, same-cycle read/write ----
    wr(31, 16'hFFFF);
    @(negedge clk);
    waddr = 5'd30; wdata = 16'h00F0; wv = 1'b1; raddr = 5'd31;
    #1;
    chk("read31_after_write", rdata, 16'hFFFF);
    raddr = 5'd30;
    #1;
    chk("read30_same_cycle_old", rdata, 16'h0000);
    chk("full31", full_rows[31], 1'b1);
    chk("full30", full_rows[30], 1'b0);
    @(posedge clk);
    #1;
    wv = 1'b0;
    model[30] = 16'h00F0;
    rd("read30_next_cycle", 30);
    chk("full30_partial", full_rows[30], 1'b0);

    // ---- scan coherence, frame, wrap ----
    n = 0;
    while (scan_addr !== 5'd10 && n < 100) begin @(negedge clk); #1; n++; end
    chk("scan_reach10", scan_addr, 5'd10);
    wr(7, 16'hA5A5);
    prev = -1; seen7 = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      chk("scan_data_coherent", scan_data, model[scan_addr]);
      chk("frame_only_last", frame, (scan_addr == 5'd31));
      if (prev == 31) chk("scan_wrap", scan_addr, 5'd0);
      if (scan_addr == 5'd7) begin
        chk("scan_row7", scan_data, 16'hA5A5);
        seen7 = 1;
      end
      prev = int'(scan_addr);
    end
    chk("scan_saw_row7", seen7, 1'b1);

    // ---- bulk clear ----
    for (int a = 0; a < 32; a++) wr(a, 16'hFFFF);
    @(negedge clk); #1;
    chk("preload_full_rows", full_rows, 32'hFFFF_FFFF);
    chk("preload_top", top, 1'b1);
    clear_v = 1'b1;
    @(posedge clk); #1;
    clear_v = 1'b0;
    cnt = 0; n = 0;
    @(negedge clk); #1;
    while (ready === 1'b0 && n < 100) begin
      cnt++;
      chk("no_done_during_clear", clear_done, 1'b0);
      if (cnt == 5) begin waddr = 5'd5; wdata = 16'h1234; wv = 1'b1; end
      if (cnt == 6) wv = 1'b0;
      if (cnt == 10) begin
        raddr = 5'd0; #1;
        chk("mid_clear_row0_intact", rdata, 16'hFFFF);
        raddr = 5'd31; #1;
        chk("mid_clear_row31_zero", rdata, 16'h0000);
      end
      @(negedge clk); #1;
      n++;
    end
    wv = 1'b0;
    chk("clear_ready_low_cycles", cnt, 32);
    chk("clear_done_pulse", clear_done, 1'b1);
    chk("ready_in_done", ready, 1'b1);
    @(negedge clk); #1;
    chk("clear_done_one_cycle", clear_done, 1'b0);
    for (int i = 0; i < 32; i++) model[i] = '0;
    for (int a = 0; a < 32; a++) rd("post_clear_read", a);
    rd("dropped_write_row5", 5);
    chk("post_clear_top", top, 1'b0);
    chk("post_clear_full_rows", full_rows, 32'h0);

    // ---- async reset mid-clear ----
    wr(3, 16'h0F0F);
    @(negedge clk);
    clear_v = 1'b1;
    @(posedge clk); #1;
    clear_v = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("midclear_ready_low", ready, 1'b0);
    raddr = 5'd3; #1;
    chk("midclear_row3", rdata, 16'h0F0F);
    #1;
    rst = 1'b1;
    #1;
    chk("async_ready", ready, 1'b1);
    chk("async_clear_done", clear_done, 1'b0);
    chk("async_scan_addr", scan_addr, 5'd0);
    chk("async_scan_data", scan_data, 16'h0);
    chk("async_frame", frame, 1'b0);
    chk("async_full_rows", full_rows, 32'h0);
    chk("async_top", top, 1'b0);
    chk("async_row3_zero", rdata, 16'h0);
    @(posedge clk); #1;
    chk("reset_held_no_done", clear_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (clear_done === 1'b1 || ready !== 1'b1) pulses++;
    end
    chk("no_done_after_reset", pulses, 0);

    // ---- height_p = 20 ----
    n = 0;
    while (scan_addr20 !== 5'd19 && n < 100) begin @(negedge clk); #1; n++; end
    chk("h20_scan_reach19", scan_addr20, 5'd19);
    chk("h20_frame_at19", frame20, 1'b1);
    @(negedge clk); #1;
    chk("h20_scan_wrap", scan_addr20, 5'd0);
    chk("h20_frame_after_wrap", frame20, 1'b0);
    @(negedge clk);
    waddr20 = 5'd25; wdata20 = 16'hFFFF; wv20 = 1'b1;
    @(posedge clk); #1;
    wv20 = 1'b0;
    @(negedge clk);
    raddr20 = 5'd25; #1;
    chk("h20_read25", rdata20, 16'h0);
    chk("h20_write25_ignored", full_rows20, 20'h0);
    chk("h20_top", top20, 1'b0);
    @(negedge clk);
    waddr20 = 5'd19; wdata20 = 16'hFFFF; wv20 = 1'b1;
    @(posedge clk); #1;
    wv20 = 1'b0;
    @(negedge clk);
    raddr20 = 5'd19; #1;
    chk("h20_read19", rdata20, 16'hFFFF);
    chk("h20_full19", full_rows20, 20'h80000);
    raddr20 = 5'd25; #1;
    chk("h20_read25_again", rdata20, 16'h0);
    clear_v20 = 1'b1;
    @(posedge clk); #1;
    clear_v20 = 1'b0;
    cnt = 0; n = 0;
    @(negedge clk); #1;
    while (ready20 === 1'b0 && n < 100) begin
      cnt++;
      @(negedge clk); #1;
      n++;
    end
    chk("h20_clear_cycles", cnt, 20);
    chk("h20_clear_done", clear_done20, 1'b1);
    raddr20 = 5'd19; #1;
    chk("h20_row19_cleared", rdata20, 16'h0);
    chk("h20_full_after_clear", full_rows20, 20'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
